alsu_ctrl: RTL
==============

# alsu_ctrl

- Sequencer and round-robin arbiter that shares one ALSU instance between NUM_REQ requesters.
- Accepts packed ALSU commands over valid/ready, presents each to the ALSU for exactly one cycle, and captures the result after the ALSU's pipeline latency.
- Returns the result tagged with the requester index.
- Sits between the requesting blocks and the ALSU's operand/control inputs.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ALSU_LAT, 2, cycles from ALSU inputs presented to alsu_out reflecting them
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester command valid; must hold, with stable command, until req_ready
- req_cmd  in  16*NUM_REQ  command i at [16i+15:16i]: A[15:13], B[12:10], opcode[9:7], cin[6], serial_in[5], direction[4], red_op_A[3], red_op_B[2], bypass_A[1], bypass_B[0]
- req_ready  out  NUM_REQ  one-hot accept pulse
- alsu_cmd  out  16  registered command to ALSU, same layout
- alsu_out  in  6  ALSU result
- rsp_valid  out  1  one-cycle response pulse, no backpressure
- rsp_id  out  $clog2(NUM_REQ)  requester index of response
- rsp_data  out  6  result
- rsp_err  out  1  command rejected (see Configuration)

## Operation
- Idle word: all alsu_cmd fields 0 (AND of 0,0, no bypass, no reduction).
- alsu_cmd carries the idle word in every cycle except the single cycle after ISSUE.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid, select winner w via round-robin, latch gnt_id<=w, go to ISSUE.
- ISSUE: req_ready[w]=1 (decoded from state, one cycle).
  - At the edge, alsu_cmd<=req_cmd[w], cnt<=0, go to WAIT.
  - Error path: go to RESP with rsp_err.
- WAIT: alsu_cmd<=idle word after the first cycle; cnt increments.
  - When cnt==ALSU_LAT: rsp_data<=alsu_out, rsp_valid<=1, rsp_id<=gnt_id, go to RESP.
- RESP: rsp_valid high for this cycle only.
  - If any req_valid, arbitrate and go straight to ISSUE; else go to IDLE.
- Round-robin: search starts at last_gnt+1 modulo NUM_REQ. last_gnt updates on every ISSUE. Reset value of last_gnt is NUM_REQ-1, so requester 0 wins first.
- Arbitration samples req_valid only in IDLE/RESP. A request raised during WAIT waits for RESP.
- Shift and rotate commands see the idle-word result (0) as the previous ALSU output. Chained shifts across transactions are not supported.

## Timing
- Reset (async assert): state IDLE, alsu_cmd=idle word, req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, last_gnt=NUM_REQ-1.
- An in-flight transaction is dropped with no response. Deassertion takes effect at the next edge.
- Normal path:
  - valid seen in IDLE at cycle t; req_ready at t+1.
  - alsu_cmd holds the command during t+2 only.
  - rsp_valid at t+3+ALSU_LAT (t+5 for default).
  - Accept-to-response is ALSU_LAT+2 cycles.
- Back-to-back: next req_ready in the cycle after RESP.
  - Throughput is one command per ALSU_LAT+3 cycles (5 for default).
- Error path: rsp_valid (rsp_err=1, rsp_data=0) in the cycle after ISSUE; alsu_cmd stays at the idle word.
- rsp_err is 0 on every non-error response.

## Configuration
- ALSU_CTRL_PRECHECK_EN defined: in ISSUE, a command is rejected when bypass_A=bypass_B=0 and either:
  - opcode is 6 or 7; or
  - (red_op_A|red_op_B)=1 with opcode>1.
  - A rejected command takes the error path; the ALSU is never driven with it.
- Not defined: all commands go to the ALSU; rsp_err is tied 0.

## Structure
- Package alsu_ctrl_pkg holds:
  - CMD_W=16 and all field offset localparams;
  - opcode localparams (OP_AND=0, OP_XOR=1, OP_ADD=2, OP_MUL=3, OP_SHIFT=4, OP_ROT=5);
  - IDLE_CMD constant;
  - the state enum.
- Sub-module alsu_rr_arb: combinational round-robin winner select from req_valid and last_gnt. Outputs are a one-hot grant and the winner index.

## Test plan
- Single add on requester 0: A=3, B=2, opcode=2, cin=0 -> req_ready[0] 1 cycle after valid; rsp_valid 4 cycles after ready; rsp_data=5, rsp_id=0.
- Multiply on requester 2: A=7, B=7, opcode=3 -> rsp_data=49, rsp_id=2.
  - alsu_cmd non-idle for exactly 1 cycle.
- All four requesters valid continuously -> grants 0,1,2,3,0 in order.
  - req_ready pulses spaced 5 cycles apart; each rsp_id matches its grant.
- With ALSU_CTRL_PRECHECK_EN: opcode=6 -> rsp_err=1, rsp_data=0 one cycle after ready, alsu_cmd stays idle.
  - Same command without the macro -> forwarded, rsp_err=0.
- rst asserted during WAIT -> all outputs reset immediately, no rsp_valid.
  - After release, a pending request from requester 0 is granted first.
- Bypass: bypass_A=1, A=5, opcode=7 -> rsp_data=5, rsp_err=0 in both configurations.

Source files
------------

// File: rtl/alsu_ctrl_pkg.sv
// Shared definitions for the ALSU sequencer: command layout, opcodes, idle word and FSM states.
package alsu_ctrl_pkg;

  localparam int unsigned CMD_W = 16;

  localparam int unsigned A_LSB      = 13;
  localparam int unsigned A_W        = 3;
  localparam int unsigned B_LSB      = 10;
  localparam int unsigned B_W        = 3;
  localparam int unsigned OP_LSB     = 7;
  localparam int unsigned OP_W       = 3;
  localparam int unsigned CIN_BIT    = 6;
  localparam int unsigned SERIAL_BIT = 5;
  localparam int unsigned DIR_BIT    = 4;
  localparam int unsigned RED_A_BIT  = 3;
  localparam int unsigned RED_B_BIT  = 2;
  localparam int unsigned BYP_A_BIT  = 1;
  localparam int unsigned BYP_B_BIT  = 0;

  localparam logic [OP_W-1:0] OP_AND   = 3'd0;
  localparam logic [OP_W-1:0] OP_XOR   = 3'd1;
  localparam logic [OP_W-1:0] OP_ADD   = 3'd2;
  localparam logic [OP_W-1:0] OP_MUL   = 3'd3;
  localparam logic [OP_W-1:0] OP_SHIFT = 3'd4;
  localparam logic [OP_W-1:0] OP_ROT   = 3'd5;

  // AND of 0,0 with no bypass and no reduction: the ALSU settles to 0.
  localparam logic [CMD_W-1:0] IDLE_CMD = '0;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  // Commands the ALSU would flag as invalid; bypass always yields a legal result.
  function automatic logic cmd_rejected(input logic [CMD_W-1:0] cmd);
    logic [OP_W-1:0] op;
    op = cmd[OP_LSB +: OP_W];
    if (cmd[BYP_A_BIT] || cmd[BYP_B_BIT]) return 1'b0;
    return (op > OP_ROT) || ((cmd[RED_A_BIT] || cmd[RED_B_BIT]) && (op > OP_XOR));
  endfunction

endpackage

// File: rtl/alsu_ctrl_rr_arb.sv
// Combinational round-robin select: search starts one past the last granted requester.
module alsu_rr_arb #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [$clog2(NUM_REQ)-1:0] last_gnt,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id
);

  localparam int unsigned IdW = $clog2(NUM_REQ);

  always_comb begin
    logic           found;
    logic [IdW-1:0] idx;
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = IdW'((32'(last_gnt) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        gnt[idx]   = 1'b1;
        gnt_id     = idx;
      end
    end
  end

endmodule

// File: rtl/alsu_ctrl.sv
// Round-robin sequencer sharing one ALSU between NUM_REQ requesters.
// Define ALSU_CTRL_PRECHECK_EN to reject invalid commands before they reach the ALSU.
module alsu_ctrl
  import alsu_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ALSU_LAT = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [CMD_W*NUM_REQ-1:0]   req_cmd,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [CMD_W-1:0]           alsu_cmd,
  input  logic [5:0]                 alsu_out,
  output logic                       rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [5:0]                 rsp_data,
  output logic                       rsp_err
);

  localparam int unsigned IdW  = $clog2(NUM_REQ);
  localparam int unsigned CntW = (ALSU_LAT < 1) ? 1 : $clog2(ALSU_LAT + 1);

  state_e           state_q, state_d;
  logic [IdW-1:0]   gnt_id_q, gnt_id_d;
  logic [IdW-1:0]   last_gnt_q, last_gnt_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [CMD_W-1:0] alsu_cmd_q, alsu_cmd_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IdW-1:0]   rsp_id_q, rsp_id_d;
  logic [5:0]       rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IdW-1:0]     arb_id;
  logic               arb_any;
  logic [CMD_W-1:0]   cur_cmd;
  logic               reject;

  alsu_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req_valid (req_valid),
    .last_gnt  (last_gnt_q),
    .gnt       (arb_gnt),
    .gnt_id    (arb_id)
  );

  assign arb_any = |arb_gnt;
  // Requesters hold their command stable until accepted, so the granted slot is safe to read.
  assign cur_cmd = req_cmd[CMD_W*gnt_id_q +: CMD_W];

`ifdef ALSU_CTRL_PRECHECK_EN
  assign reject = cmd_rejected(cur_cmd);
`else
  assign reject = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    gnt_id_d    = gnt_id_q;
    last_gnt_d  = last_gnt_q;
    cnt_d       = cnt_q;
    alsu_cmd_d  = IDLE_CMD;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = 1'b0;
    req_ready   = '0;

    unique case (state_q)
      StIdle: begin
        if (arb_any) begin
          gnt_id_d = arb_id;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        req_ready[gnt_id_q] = 1'b1;
        last_gnt_d          = gnt_id_q;
        if (reject) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = gnt_id_q;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          state_d     = StResp;
        end else begin
          alsu_cmd_d = cur_cmd;
          cnt_d      = '0;
          state_d    = StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q + 1'b1;
        // alsu_out reflects the command ALSU_LAT cycles after it was presented.
        if (cnt_q == CntW'(ALSU_LAT)) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = gnt_id_q;
          rsp_data_d  = alsu_out;
          state_d     = StResp;
        end
      end
      StResp: begin
        if (arb_any) begin
          gnt_id_d = arb_id;
          state_d  = StIssue;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      gnt_id_q    <= '0;
      last_gnt_q  <= IdW'(NUM_REQ - 1);
      cnt_q       <= '0;
      alsu_cmd_q  <= IDLE_CMD;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_id_q    <= gnt_id_d;
      last_gnt_q  <= last_gnt_d;
      cnt_q       <= cnt_d;
      alsu_cmd_q  <= alsu_cmd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign alsu_cmd  = alsu_cmd_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule
